// File: rtl/keypad_scan_controller_pkg.sv
// rtl/keypad_scan_controller_pkg.sv - shared state encoding, pin constants and index helpers
package keypad_scan_controller_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } scan_state_e;

   // Column 0 strobed (active-low) and the all-released row pattern.
   localparam logic [3:0] COL_RESET = 4'b1110;
   localparam logic [3:0] ROW_IDLE  = 4'b1111;

   // Position of the single low bit of a one-hot active-low column strobe.
   function automatic logic [1:0] col_to_idx(input logic [3:0] col);
      logic [1:0] idx;
      idx = 2'd0;
      case (col)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Lowest pulled-low row wins when several keys share a column.
   function automatic logic [1:0] row_to_idx(input logic [3:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      if (!rows[0])      idx = 2'd0;
      else if (!rows[1]) idx = 2'd1;
      else if (!rows[2]) idx = 2'd2;
      else if (!rows[3]) idx = 2'd3;
      return idx;
   endfunction

   // Advance the strobe to the next column, wrapping 3 -> 0.
   function automatic logic [3:0] rotate_col(input logic [3:0] col);
      return {col[2:0], col[3]};
   endfunction

endpackage

// File: rtl/keypad_scan_controller_if.sv
// rtl/keypad_scan_controller_if.sv - keypad pins and key-event outputs bundled as one interface
interface keypad_scan_controller_if;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_value;
   logic       key_valid;
   logic       key_held;

   // Scanner side: reads rows, drives strobes and key events.
   modport master (
      input  row,
      output col,
      output key_value,
      output key_valid,
      output key_held
   );

   // Keypad / consumer side.
   modport slave (
      output row,
      input  col,
      input  key_value,
      input  key_valid,
      input  key_held
   );
endinterface

// File: rtl/keypad_scan_controller_scan_tick_gen.sv
// rtl/keypad_scan_controller_scan_tick_gen.sv - free-running column dwell counter producing the scan tick
module scan_tick_gen #(
   parameter int SCAN_DIV = 1000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Count 0..SCAN_DIV-1 and wrap; never paused by the scanner state.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end
   end

   // Dwell counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/keypad_scan_controller.sv
// rtl/keypad_scan_controller.sv - 4x4 keypad column scanner with press/release debounce
module keypad_scan_controller
   import keypad_scan_controller_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   keypad_scan_controller_if.master kp
);

   localparam int DW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DW-1:0] DEB_TARGET = DW'(DEBOUNCE_CNT);

   logic        tick;
   logic [3:0]  row_meta_q;
   logic [3:0]  row_sync_q;

   scan_state_e state_q, state_d;
   logic [3:0]    col_q, col_d;
   logic [3:0]    cand_q, cand_d;
   logic [DW-1:0] deb_q, deb_d;
   logic [3:0]    key_value_q, key_value_d;
   logic          key_valid_q, key_valid_d;
   logic          key_held_q, key_held_d;

   logic [3:0]    code;
   logic          row_idle;
   logic [DW-1:0] deb_inc;

   scan_tick_gen #(
      .SCAN_DIV(SCAN_DIV)
   ) u_tick (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );

   // Two-flop synchroniser for the asynchronous row pins; idles released.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_meta_q <= ROW_IDLE;
         row_sync_q <= ROW_IDLE;
      end else begin
         row_meta_q <= kp.row;
         row_sync_q <= row_meta_q;
      end
   end

   assign code     = {col_to_idx(col_q), row_to_idx(row_sync_q)};
   assign row_idle = (row_sync_q == ROW_IDLE);
   assign deb_inc  = deb_q + DW'(1);

   // Scan/debounce/held sequencing; everything advances only on a tick.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      cand_d      = cand_q;
      deb_d       = deb_q;
      key_value_d = key_value_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;

      if (tick) begin
         unique case (state_q)
            SCAN: begin
               if (row_idle) begin
                  col_d = rotate_col(col_q);
               end else begin
                  cand_d  = code;
                  deb_d   = '0;
                  state_d = DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (!row_idle && (code == cand_q)) begin
                  if (deb_inc == DEB_TARGET) begin
                     key_value_d = cand_q;
                     key_valid_d = 1'b1;
                     key_held_d  = 1'b1;
                     deb_d       = '0;
                     state_d     = HELD;
                  end else begin
                     deb_d = deb_inc;
                  end
               end else begin
                  // Bounce or a different key: abandon and move on.
                  col_d   = rotate_col(col_q);
                  deb_d   = '0;
                  state_d = SCAN;
               end
            end
            HELD: begin
               if (row_idle) begin
                  if (deb_inc == DEB_TARGET) begin
                     key_held_d = 1'b0;
                     deb_d      = '0;
                     col_d      = rotate_col(col_q);
                     state_d    = SCAN;
                  end else begin
                     deb_d = deb_inc;
                  end
               end else begin
                  // Release must be seen on consecutive ticks.
                  deb_d = '0;
               end
            end
            default: begin
               col_d   = COL_RESET;
               deb_d   = '0;
               state_d = SCAN;
            end
         endcase
      end
   end

   // Scanner state, strobe and key-event registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= SCAN;
         col_q       <= COL_RESET;
         cand_q      <= 4'd0;
         deb_q       <= '0;
         key_value_q <= 4'd0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         cand_q      <= cand_d;
         deb_q       <= deb_d;
         key_value_q <= key_value_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   assign kp.col       = col_q;
   assign kp.key_value = key_value_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_held  = key_held_q;

endmodule
